// File: rtl/riscv_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_rf_pkg
// Description : Shared constants and types for the register file writeback
//               arbiter and its round-robin sub-arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_rf_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // Writeback arbiter operating state: CLEAR sweeps x1..x31, RUN arbitrates.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    // Requester indices into the req/gnt vectors.
    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    // Index of the requester that did not win a 2-way grant.
    function automatic logic other_req(input logic [1:0] gnt);
        return gnt[REQ_ALU] ? 1'(REQ_LSU) : 1'(REQ_ALU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rf_rr_arbiter2
// Description : Two-way round-robin grant logic with its priority pointer.
//               With rr_en low the pointer is pinned to the LSU requester.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       rr_en,
    output logic [1:0] gnt
);
    import riscv_rf_pkg::*;

    // prio holds the index of the requester that wins a tie.
    logic prio_q;
    logic prio_d;

    // Grant a lone requester directly; on a tie grant the prio side.
    always_comb begin
        gnt    = 2'b00;
        prio_d = prio_q;
        if (enable) begin
            if (req == 2'b11) begin
                gnt[prio_q] = 1'b1;
            end else begin
                gnt = req;
            end
            if (|gnt) begin
                prio_d = other_req(gnt);
            end
        end
        if (!rr_en) begin
            prio_d = 1'(REQ_LSU);
        end
    end

    // Priority pointer register; LSU wins ties first out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'(REQ_LSU);
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Owns the register file write port. Clears x1..x(N-1) after
//               reset or on request, then arbitrates ALU and LSU writeback
//               beats onto a registered write port and counts conflicts.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int XLEN   = riscv_rf_pkg::XLEN,
    parameter int REG_AW = riscv_rf_pkg::REG_AW,
    parameter int CNT_W  = 16,
    parameter int RR_EN  = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ALU_VALID,
    input  logic [REG_AW-1:0] ALU_RD,
    input  logic [XLEN-1:0]   ALU_WD,
    output logic              ALU_READY,
    input  logic              LSU_VALID,
    input  logic [REG_AW-1:0] LSU_RD,
    input  logic [XLEN-1:0]   LSU_WD,
    output logic              LSU_READY,
    input  logic              CLR_REQ,
    output logic              BUSY,
    output logic              RegWrite,
    output logic [REG_AW-1:0] A3,
    output logic [XLEN-1:0]   WD,
    output logic [CNT_W-1:0]  CONFLICT_CNT
);
    import riscv_rf_pkg::*;

    localparam logic [REG_AW-1:0] CLR_LAST = {REG_AW{1'b1}};
    localparam logic [REG_AW-1:0] CLR_FIRST = REG_AW'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    rf_state_e         state_q,        state_d;
    logic [REG_AW-1:0] clr_cnt_q,      clr_cnt_d;
    logic              reg_write_q,    reg_write_d;
    logic [REG_AW-1:0] a3_q,           a3_d;
    logic [XLEN-1:0]   wd_q,           wd_d;
    logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

    logic              arb_en;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_wd;

    // A clear request blocks grants in the very cycle it is seen.
    assign arb_en          = (state_q == RUN) && !CLR_REQ;
    assign req[REQ_ALU]    = ALU_VALID;
    assign req[REQ_LSU]    = LSU_VALID;

    rf_rr_arbiter2 u_arb (
        .clk    (CLK),
        .rst_n  (RST_N),
        .req    (req),
        .enable (arb_en),
        .rr_en  (RR_EN != 0),
        .gnt    (gnt)
    );

    assign ALU_READY = gnt[REQ_ALU];
    assign LSU_READY = gnt[REQ_LSU];
    assign sel_rd    = gnt[REQ_LSU] ? LSU_RD : ALU_RD;
    assign sel_wd    = gnt[REQ_LSU] ? LSU_WD : ALU_WD;

    // Next-state, clear sequencing, write port and conflict counter.
    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        reg_write_d    = 1'b0;
        a3_d           = a3_q;
        wd_d           = wd_q;
        conflict_cnt_d = conflict_cnt_q;
        case (state_q)
            CLEAR: begin
                reg_write_d = 1'b1;
                a3_d        = clr_cnt_q;
                wd_d        = '0;
                clr_cnt_d   = clr_cnt_q + REG_AW'(1);
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Conflicts are counted even when CLR_REQ suppresses grants.
                if (ALU_VALID && LSU_VALID && (conflict_cnt_q != CNT_MAX)) begin
                    conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
                end
                if (CLR_REQ) begin
                    state_d   = CLEAR;
                    clr_cnt_d = CLR_FIRST;
                end else if ((|gnt) && (sel_rd != REG_AW'(REG_ZERO))) begin
                    // Beats to x0 are accepted but dropped here.
                    reg_write_d = 1'b1;
                    a3_d        = sel_rd;
                    wd_d        = sel_wd;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = CLR_FIRST;
            end
        endcase
    end

    // State and output registers; reset restarts the clear at x1.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= CLEAR;
            clr_cnt_q      <= CLR_FIRST;
            reg_write_q    <= 1'b0;
            a3_q           <= '0;
            wd_q           <= '0;
            conflict_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            reg_write_q    <= reg_write_d;
            a3_q           <= a3_d;
            wd_q           <= wd_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign BUSY         = (state_q == CLEAR);
    assign RegWrite     = reg_write_q;
    assign A3           = a3_q;
    assign WD           = wd_q;
    assign CONFLICT_CNT = conflict_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench. Three instances share stimulus:
//               round-robin (main), fixed priority, and a 4-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, lsu_valid, clr_req;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_wd, lsu_wd;

    logic        a_alu_ready, a_lsu_ready, a_busy, a_we;
    logic [4:0]  a_a3;
    logic [31:0] a_wd;
    logic [15:0] a_cnt;

    logic        f_alu_ready, f_lsu_ready, f_busy, f_we;
    logic [4:0]  f_a3;
    logic [31:0] f_wd;
    logic [15:0] f_cnt;

    logic        c_alu_ready, c_lsu_ready, c_busy, c_we;
    logic [4:0]  c_a3;
    logic [31:0] c_wd;
    logic [3:0]  c_cnt;

    int   total = 0;
    int   bad   = 0;
    int   cnt_model = 0;
    logic prio_lsu = 1'b1;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(32), .REG_AW(5), .CNT_W(16), .RR_EN(1)) dut (
        .CLK(clk), .RST_N(rst_n),
        .ALU_VALID(alu_valid), .ALU_RD(alu_rd), .ALU_WD(alu_wd), .ALU_READY(a_alu_ready),
        .LSU_VALID(lsu_valid), .LSU_RD(lsu_rd), .LSU_WD(lsu_wd), .LSU_READY(a_lsu_ready),
        .CLR_REQ(clr_req), .BUSY(a_busy), .RegWrite(a_we), .A3(a_a3), .WD(a_wd),
        .CONFLICT_CNT(a_cnt)
    );

    regfile_wb_arbiter #(.XLEN(32), .REG_AW(5), .CNT_W(16), .RR_EN(0)) dut_fp (
        .CLK(clk), .RST_N(rst_n),
        .ALU_VALID(alu_valid), .ALU_RD(alu_rd), .ALU_WD(alu_wd), .ALU_READY(f_alu_ready),
        .LSU_VALID(lsu_valid), .LSU_RD(lsu_rd), .LSU_WD(lsu_wd), .LSU_READY(f_lsu_ready),
        .CLR_REQ(clr_req), .BUSY(f_busy), .RegWrite(f_we), .A3(f_a3), .WD(f_wd),
        .CONFLICT_CNT(f_cnt)
    );

    regfile_wb_arbiter #(.XLEN(32), .REG_AW(5), .CNT_W(4), .RR_EN(1)) dut_c4 (
        .CLK(clk), .RST_N(rst_n),
        .ALU_VALID(alu_valid), .ALU_RD(alu_rd), .ALU_WD(alu_wd), .ALU_READY(c_alu_ready),
        .LSU_VALID(lsu_valid), .LSU_RD(lsu_rd), .LSU_WD(lsu_wd), .LSU_READY(c_lsu_ready),
        .CLR_REQ(clr_req), .BUSY(c_busy), .RegWrite(c_we), .A3(c_a3), .WD(c_wd),
        .CONFLICT_CNT(c_cnt)
    );

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n clear beats, expecting A3 = 1..n with WD = 0 and no grants.
    task automatic test_clear_beats(input int n);
        logic [37:0] exp_port;
        for (int i = 1; i <= n; i++) begin
            total++;
            if ({a_alu_ready, a_lsu_ready} !== 2'b00) begin
                bad++;
                $display("FAIL clear_ready beat=%0d got=%b exp=00", i, {a_alu_ready, a_lsu_ready});
            end
            tick();
            exp_port = {1'b1, 5'(i), 32'h0};
            total++;
            if ({a_we, a_a3, a_wd} !== exp_port) begin
                bad++;
                $display("FAIL clear_beat beat=%0d got=%h exp=%h", i, {a_we, a_a3, a_wd}, exp_port);
            end
            total++;
            if (a_busy !== (i < 31)) begin
                bad++;
                $display("FAIL clear_busy beat=%0d got=%b exp=%b", i, a_busy, (i < 31));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_valid = 1'b1; lsu_valid = 1'b1; clr_req = 1'b0;
        alu_rd = 5'd3; alu_wd = 32'hA5A5_0003;
        lsu_rd = 5'd7; lsu_wd = 32'h5A5A_0007;
        tick();
        tick();
        total++;
        if ({a_we, a_a3, a_wd} !== 38'h0) begin
            bad++;
            $display("FAIL reset_port got=%h exp=0", {a_we, a_a3, a_wd});
        end
        total++;
        if ({a_busy, a_alu_ready, a_lsu_ready} !== 3'b100) begin
            bad++;
            $display("FAIL reset_busy_ready got=%b exp=100", {a_busy, a_alu_ready, a_lsu_ready});
        end
        total++;
        if ({a_cnt, c_cnt} !== 20'h0) begin
            bad++;
            $display("FAIL reset_cnt got=%h exp=0", {a_cnt, c_cnt});
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_clear_after_reset();
        test_clear_beats(31);
        tick();
        total++;
        if ({a_we, a_busy, a_alu_ready, a_lsu_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL idle_after_clear got=%b exp=0000", {a_we, a_busy, a_alu_ready, a_lsu_ready});
        end
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
        #1;
        total++;
        if ({a_alu_ready, a_lsu_ready} !== 2'b10) begin
            bad++;
            $display("FAIL single_ready got=%b exp=10", {a_alu_ready, a_lsu_ready});
        end
        tick();
        alu_valid = 1'b0;
        prio_lsu = 1'b1;
        total++;
        if ({a_we, a_a3, a_wd} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL single_write got=%h exp=%h", {a_we, a_a3, a_wd}, {1'b1, 5'd5, 32'hDEADBEEF});
        end
        tick();
        total++;
        if ({a_we, a_a3, a_wd} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL single_hold got=%h exp=%h", {a_we, a_a3, a_wd}, {1'b0, 5'd5, 32'hDEADBEEF});
        end
    endtask

    task automatic test_back_to_back();
        logic [37:0] exp_port;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'hA5A5_0003;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'h5A5A_0007;
        for (int i = 0; i < 20; i++) begin
            #1;
            total++;
            if ({a_alu_ready, a_lsu_ready} !== {~prio_lsu, prio_lsu}) begin
                bad++;
                $display("FAIL rr_grant cyc=%0d got=%b exp=%b", i, {a_alu_ready, a_lsu_ready}, {~prio_lsu, prio_lsu});
            end
            total++;
            if ({f_alu_ready, f_lsu_ready} !== 2'b01) begin
                bad++;
                $display("FAIL fixed_grant cyc=%0d got=%b exp=01", i, {f_alu_ready, f_lsu_ready});
            end
            exp_port = prio_lsu ? {1'b1, 5'd7, 32'h5A5A_0007} : {1'b1, 5'd3, 32'hA5A5_0003};
            tick();
            cnt_model++;
            prio_lsu = ~prio_lsu;
            total++;
            if ({a_we, a_a3, a_wd} !== exp_port) begin
                bad++;
                $display("FAIL rr_write cyc=%0d got=%h exp=%h", i, {a_we, a_a3, a_wd}, exp_port);
            end
            total++;
            if ({f_we, f_a3} !== {1'b1, 5'd7}) begin
                bad++;
                $display("FAIL fixed_write cyc=%0d got=%h exp=%h", i, {f_we, f_a3}, {1'b1, 5'd7});
            end
            total++;
            if (a_cnt !== 16'(cnt_model)) begin
                bad++;
                $display("FAIL conflict_cnt cyc=%0d got=%0d exp=%0d", i, a_cnt, cnt_model);
            end
            total++;
            if (c_cnt !== 4'((cnt_model > 15) ? 15 : cnt_model)) begin
                bad++;
                $display("FAIL conflict_sat cyc=%0d got=%0d exp=%0d", i, c_cnt, (cnt_model > 15) ? 15 : cnt_model);
            end
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
    endtask

    task automatic test_rd_zero();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_wd = 32'h1;
        #1;
        total++;
        if ({a_alu_ready, a_lsu_ready} !== 2'b01) begin
            bad++;
            $display("FAIL rd0_ready got=%b exp=01", {a_alu_ready, a_lsu_ready});
        end
        tick();
        prio_lsu = 1'b0;
        total++;
        if (a_we !== 1'b0) begin
            bad++;
            $display("FAIL rd0_no_write got=%b exp=0", a_we);
        end
        alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'hA5A5_0003;
        lsu_rd = 5'd7; lsu_wd = 32'h5A5A_0007;
        #1;
        total++;
        if ({a_alu_ready, a_lsu_ready} !== 2'b10) begin
            bad++;
            $display("FAIL rd0_prio_alu got=%b exp=10", {a_alu_ready, a_lsu_ready});
        end
        tick();
        cnt_model++;
        prio_lsu = 1'b1;
        total++;
        if ({a_we, a_a3, a_wd} !== {1'b1, 5'd3, 32'hA5A5_0003}) begin
            bad++;
            $display("FAIL rd0_next_write got=%h exp=%h", {a_we, a_a3, a_wd}, {1'b1, 5'd3, 32'hA5A5_0003});
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
    endtask

    task automatic test_clear_req();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_wd = 32'h0000_0909;
        tick();
        prio_lsu = 1'b1;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'h5A5A_0007;
        clr_req = 1'b1;
        #1;
        total++;
        if ({a_alu_ready, a_lsu_ready, f_alu_ready, f_lsu_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL clrreq_ready got=%b exp=0000", {a_alu_ready, a_lsu_ready, f_alu_ready, f_lsu_ready});
        end
        total++;
        if ({a_we, a_a3, a_wd} !== {1'b1, 5'd9, 32'h0000_0909}) begin
            bad++;
            $display("FAIL clrreq_prev_write got=%h exp=%h", {a_we, a_a3, a_wd}, {1'b1, 5'd9, 32'h0000_0909});
        end
        tick();
        cnt_model++;
        clr_req = 1'b0;
        total++;
        if ({a_we, a_busy} !== 2'b01) begin
            bad++;
            $display("FAIL clrreq_enter got=%b exp=01", {a_we, a_busy});
        end
        test_clear_beats(31);
        total++;
        if (a_cnt !== 16'(cnt_model)) begin
            bad++;
            $display("FAIL clear_no_count got=%0d exp=%0d", a_cnt, cnt_model);
        end
        alu_rd = 5'd3; alu_wd = 32'hA5A5_0003;
        #1;
        total++;
        if ({a_alu_ready, a_lsu_ready} !== {~prio_lsu, prio_lsu}) begin
            bad++;
            $display("FAIL resume_grant got=%b exp=%b", {a_alu_ready, a_lsu_ready}, {~prio_lsu, prio_lsu});
        end
        tick();
        cnt_model++;
        total++;
        if ({a_we, a_a3} !== {1'b1, 5'd7}) begin
            bad++;
            $display("FAIL resume_write got=%h exp=%h", {a_we, a_a3}, {1'b1, 5'd7});
        end
        total++;
        if (a_cnt !== 16'(cnt_model)) begin
            bad++;
            $display("FAIL resume_cnt got=%0d exp=%0d", a_cnt, cnt_model);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_clear();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        test_clear_beats(10);
        #2;
        rst_n = 1'b0;
        #1;
        cnt_model = 0;
        prio_lsu  = 1'b1;
        total++;
        if ({a_we, a_a3, a_wd} !== 38'h0) begin
            bad++;
            $display("FAIL async_reset_port got=%h exp=0", {a_we, a_a3, a_wd});
        end
        total++;
        if ({a_busy, a_cnt} !== {1'b1, 16'h0}) begin
            bad++;
            $display("FAIL async_reset_busy_cnt got=%h exp=%h", {a_busy, a_cnt}, {1'b1, 16'h0});
        end
        tick();
        rst_n = 1'b1;
        test_clear_beats(31);
        alu_valid = 1'b1; lsu_valid = 1'b1;
        #1;
        total++;
        if ({a_alu_ready, a_lsu_ready} !== 2'b01) begin
            bad++;
            $display("FAIL post_reset_prio got=%b exp=01", {a_alu_ready, a_lsu_ready});
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_clear_after_reset();
        test_single_alu();
        test_back_to_back();
        test_rd_zero();
        test_clear_req();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
